// File: rtl/audio_frame_pkg.sv
// Shared types and helpers for the audio frame FIFO.
package audio_frame_pkg;

  typedef enum logic {ASSEMBLE = 1'b0, RESYNC = 1'b1} state_e;

  localparam int ERR_COUNT_W = 16;

  function automatic logic [ERR_COUNT_W-1:0] sat_inc(input logic [ERR_COUNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/fifo_1r1w_sync.sv
// Single-clock 2^depth_log2-entry FIFO with extra-MSB pointers.
// Optional occupancy output under AUDIO_FRAME_FIFO_LEVEL_EN.
module fifo_1r1w_sync #(
  parameter int width      = 48,
  parameter int depth_log2 = 4
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               wr_en_i,
  input  logic [width-1:0]   wr_data_i,
  input  logic               rd_en_i,
  output logic [width-1:0]   rd_data_o,
`ifdef AUDIO_FRAME_FIFO_LEVEL_EN
  output logic [depth_log2:0] level_o,
`endif
  output logic               full_o,
  output logic               empty_o
);

  localparam int DEPTH = 1 << depth_log2;

  logic [depth_log2:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [width-1:0]    mem_q [DEPTH];
  logic                do_wr, do_rd;

  assign full_o  = (wr_ptr_q ^ rd_ptr_q) == {1'b1, {depth_log2{1'b0}}};
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign do_wr   = wr_en_i & ~full_o;
  assign do_rd   = rd_en_i & ~empty_o;
  assign wr_ptr_d = do_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
  assign rd_ptr_d = do_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;

  assign rd_data_o = mem_q[rd_ptr_q[depth_log2-1:0]];

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q[depth_log2-1:0]] <= wr_data_i;
  end

`ifdef AUDIO_FRAME_FIFO_LEVEL_EN
  logic [depth_log2:0] level_q;
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) level_q <= '0;
    else            level_q <= wr_ptr_d - rd_ptr_d;
  end
  assign level_o = level_q;
`endif

endmodule

// File: rtl/audio_frame_fifo.sv
// Serial per-channel samples -> parallel frames -> FIFO, with framing-error resync.
// Define AUDIO_FRAME_FIFO_LEVEL_EN to expose FIFO occupancy on level_o.
module audio_frame_fifo
  import audio_frame_pkg::*;
#(
  parameter int width_p      = 24,
  parameter int channels_p   = 2,
  parameter int depth_log2_p = 4
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic                          valid_i,
  input  logic [width_p-1:0]            data_i,
  input  logic                          last_i,
  output logic                          ready_o,
  output logic                          valid_o,
  output logic [channels_p*width_p-1:0] data_o,
  input  logic                          ready_i,
`ifdef AUDIO_FRAME_FIFO_LEVEL_EN
  output logic [depth_log2_p:0]         level_o,
`endif
  output logic                          err_o,
  output logic [ERR_COUNT_W-1:0]        err_count_o
);

  localparam int CH_W = (channels_p > 1) ? $clog2(channels_p) : 1;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(channels_p - 1);

  state_e                                  state_q, state_d;
  logic [CH_W-1:0]                         ch_q, ch_d;
  logic                                    err_q, err_d;
  logic [ERR_COUNT_W-1:0]                  err_cnt_q;
  logic [channels_p-1:0][width_p-1:0]      lane_q, wr_data;
  logic                                    acc, at_last, lane_we, fifo_we;
  logic                                    full, empty;

  assign at_last = (ch_q == LAST_CH);
  // Gate with the reset pin so ready_o drops the moment reset is asserted.
  assign ready_o = reset_n_i & ((state_q == RESYNC) | ~at_last | ~full);
  assign acc     = valid_i & ready_o;

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    err_d   = 1'b0;
    lane_we = 1'b0;
    fifo_we = 1'b0;
    case (state_q)
      ASSEMBLE: if (acc) begin
        if (!at_last && !last_i) begin
          lane_we = 1'b1;
          ch_d    = ch_q + 1'b1;
        end else if (at_last && last_i) begin
          fifo_we = 1'b1;
          ch_d    = '0;
        end else if (!at_last) begin
          // Early last: the stream is still aligned, just drop the partial frame.
          err_d = 1'b1;
          ch_d  = '0;
        end else begin
          err_d   = 1'b1;
          ch_d    = '0;
          state_d = RESYNC;
        end
      end
      RESYNC: if (acc && last_i) begin
        state_d = ASSEMBLE;
        ch_d    = '0;
      end
      default: state_d = ASSEMBLE;
    endcase
  end

  // The final lane comes straight from data_i so the frame is written in one cycle.
  always_comb begin
    wr_data               = lane_q;
    wr_data[channels_p-1] = data_i;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= ASSEMBLE;
      ch_q      <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
      lane_q    <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      err_q   <= err_d;
      if (err_d)   err_cnt_q    <= sat_inc(err_cnt_q);
      if (lane_we) lane_q[ch_q] <= data_i;
    end
  end

  assign err_o       = err_q;
  assign err_count_o = err_cnt_q;
  assign valid_o     = ~empty;

  fifo_1r1w_sync #(
    .width      (channels_p * width_p),
    .depth_log2 (depth_log2_p)
  ) u_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .wr_en_i   (fifo_we),
    .wr_data_i (wr_data),
    .rd_en_i   (ready_i),
    .rd_data_o (data_o),
`ifdef AUDIO_FRAME_FIFO_LEVEL_EN
    .level_o   (level_o),
`endif
    .full_o    (full),
    .empty_o   (empty)
  );

endmodule

// File: tb/tb_audio_frame_fifo.sv
// Directed self-checking bench for audio_frame_fifo (2 channels x 24 bits, 16 frames).
module tb_audio_frame_fifo;

  logic        clk = 1'b0;
  logic        reset_n_i = 1'b0;
  logic        valid_i = 1'b0;
  logic [23:0] data_i = '0;
  logic        last_i = 1'b0;
  logic        ready_o;
  logic        valid_o;
  logic [47:0] data_o;
  logic        ready_i = 1'b0;
  logic        err_o;
  logic [15:0] err_count_o;
`ifdef AUDIO_FRAME_FIFO_LEVEL_EN
  logic [4:0]  level_o;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  audio_frame_fifo #(.width_p(24), .channels_p(2), .depth_log2_p(4)) dut (
    .clk_i       (clk),
    .reset_n_i   (reset_n_i),
    .valid_i     (valid_i),
    .data_i      (data_i),
    .last_i      (last_i),
    .ready_o     (ready_o),
    .valid_o     (valid_o),
    .data_o      (data_o),
    .ready_i     (ready_i),
`ifdef AUDIO_FRAME_FIFO_LEVEL_EN
    .level_o     (level_o),
`endif
    .err_o       (err_o),
    .err_count_o (err_count_o)
  );

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Present one sample and hold it until accepted (bounded wait).
  task automatic send(input logic [23:0] d, input logic l);
    int n = 0;
    valid_i = 1'b1; data_i = d; last_i = l;
    while (!ready_o && n < 40) begin step(); n++; end
    if (!ready_o) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: ready_o=%0b required 1", ready_o);
    end
    step();
    valid_i = 1'b0; last_i = 1'b0;
  endtask

  task automatic test_reset();
    step(); step();
    n_cmp++; if (ready_o !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %0b exp 0", ready_o); end
    n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %0b exp 0", valid_o); end
    n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %0b exp 0", err_o); end
    n_cmp++; if (err_count_o !== 16'd0) begin n_bad++; $display("FAIL rst_cnt: got %0h exp 0", err_count_o); end
    reset_n_i = 1'b1;
    step();
    n_cmp++; if (ready_o !== 1'b1) begin n_bad++; $display("FAIL rst_rel_ready: got %0b exp 1", ready_o); end
  endtask

  task automatic test_basic();
    ready_i = 1'b1;
    send(24'h000001, 1'b0);
    send(24'h000002, 1'b1);
    n_cmp++; if (valid_o !== 1'b1) begin n_bad++; $display("FAIL basic_valid: got %0b exp 1", valid_o); end
    n_cmp++; if (data_o !== 48'h000002_000001) begin n_bad++; $display("FAIL basic_data: got %h exp 000002000001", data_o); end
    n_cmp++; if (err_count_o !== 16'd0) begin n_bad++; $display("FAIL basic_cnt: got %0h exp 0", err_count_o); end
    step();
    n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL basic_drained: got %0b exp 0", valid_o); end
  endtask

  task automatic test_full();
    logic [47:0] exp;
    ready_i = 1'b0;
    for (int i = 0; i < 16; i++) begin
      send(24'h000100 + 24'(i), 1'b0);
      send(24'h000200 + 24'(i), 1'b1);
    end
`ifdef AUDIO_FRAME_FIFO_LEVEL_EN
    n_cmp++; if (level_o !== 5'd16) begin n_bad++; $display("FAIL full_level: got %0d exp 16", level_o); end
`endif
    n_cmp++; if (ready_o !== 1'b1) begin n_bad++; $display("FAIL full_ready_lane0: got %0b exp 1", ready_o); end
    send(24'h000AAA, 1'b0);
    n_cmp++; if (ready_o !== 1'b0) begin n_bad++; $display("FAIL full_ready_lane1: got %0b exp 0", ready_o); end
    ready_i = 1'b1;
    #1;
    n_cmp++; if (ready_o !== 1'b0) begin n_bad++; $display("FAIL full_no_comb_path: got %0b exp 0", ready_o); end
    n_cmp++; if (data_o !== 48'h000200_000100) begin n_bad++; $display("FAIL full_head: got %h exp 000200000100", data_o); end
    step();
    ready_i = 1'b0;
    n_cmp++; if (ready_o !== 1'b1) begin n_bad++; $display("FAIL full_ready_after_read: got %0b exp 1", ready_o); end
    send(24'h000BBB, 1'b1);
    ready_i = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      exp = (i == 16) ? 48'h000BBB_000AAA : {24'h000200 + 24'(i), 24'h000100 + 24'(i)};
      n_cmp++;
      if (valid_o !== 1'b1 || data_o !== exp) begin
        n_bad++; $display("FAIL drain_%0d: got v=%0b d=%h exp v=1 d=%h", i, valid_o, data_o, exp);
      end
      step();
    end
    n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL drain_empty: got %0b exp 0", valid_o); end
`ifdef AUDIO_FRAME_FIFO_LEVEL_EN
    n_cmp++; if (level_o !== 5'd0) begin n_bad++; $display("FAIL drain_level: got %0d exp 0", level_o); end
`endif
  endtask

  task automatic test_early_last();
    ready_i = 1'b1;
    send(24'h000011, 1'b1);
    n_cmp++; if (err_o !== 1'b1) begin n_bad++; $display("FAIL early_err: got %0b exp 1", err_o); end
    n_cmp++; if (err_count_o !== 16'd1) begin n_bad++; $display("FAIL early_cnt: got %0d exp 1", err_count_o); end
    n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL early_nowrite: got %0b exp 0", valid_o); end
    step();
    n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL early_pulse: got %0b exp 0", err_o); end
    send(24'h000021, 1'b0);
    send(24'h000022, 1'b1);
    n_cmp++; if (valid_o !== 1'b1 || data_o !== 48'h000022_000021) begin
      n_bad++; $display("FAIL early_next: got v=%0b d=%h exp v=1 d=000022000021", valid_o, data_o); end
    step();
  endtask

  task automatic test_missing_last();
    ready_i = 1'b1;
    send(24'h000031, 1'b0);
    send(24'h000032, 1'b0);
    n_cmp++; if (err_o !== 1'b1 || err_count_o !== 16'd2) begin
      n_bad++; $display("FAIL miss_err: got err=%0b cnt=%0d exp err=1 cnt=2", err_o, err_count_o); end
    send(24'h000033, 1'b0);
    n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL miss_single_pulse: got %0b exp 0", err_o); end
    send(24'h000034, 1'b1);
    n_cmp++; if (valid_o !== 1'b0 || err_count_o !== 16'd2) begin
      n_bad++; $display("FAIL miss_discard: got v=%0b cnt=%0d exp v=0 cnt=2", valid_o, err_count_o); end
    send(24'h000035, 1'b0);
    send(24'h000036, 1'b1);
    n_cmp++; if (valid_o !== 1'b1 || data_o !== 48'h000036_000035) begin
      n_bad++; $display("FAIL miss_next: got v=%0b d=%h exp v=1 d=000036000035", valid_o, data_o); end
    step();
  endtask

  task automatic test_reset_mid();
    ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send(24'h000050 + 24'(i), 1'b0);
      send(24'h000060 + 24'(i), 1'b1);
    end
    send(24'h000077, 1'b0);
    reset_n_i = 1'b0;
    #1;
    n_cmp++; if (valid_o !== 1'b0 || ready_o !== 1'b0) begin
      n_bad++; $display("FAIL midrst_async: got v=%0b r=%0b exp 0 0", valid_o, ready_o); end
    n_cmp++; if (err_count_o !== 16'd0) begin n_bad++; $display("FAIL midrst_cnt: got %0d exp 0", err_count_o); end
    step();
    reset_n_i = 1'b1;
    step();
    n_cmp++; if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
      n_bad++; $display("FAIL midrst_release: got v=%0b r=%0b exp 0 1", valid_o, ready_o); end
`ifdef AUDIO_FRAME_FIFO_LEVEL_EN
    n_cmp++; if (level_o !== 5'd0) begin n_bad++; $display("FAIL midrst_level: got %0d exp 0", level_o); end
`endif
    ready_i = 1'b1;
    send(24'h000041, 1'b0);
    send(24'h000042, 1'b1);
    n_cmp++; if (valid_o !== 1'b1 || data_o !== 48'h000042_000041 || err_o !== 1'b0) begin
      n_bad++; $display("FAIL midrst_frame: got v=%0b d=%h e=%0b exp v=1 d=000042000041 e=0", valid_o, data_o, err_o); end
    step();
  endtask

  task automatic test_saturate();
    valid_i = 1'b1; last_i = 1'b1; data_i = 24'h0000EE;
    repeat (100) @(posedge clk);
    #1;
    n_cmp++; if (err_count_o !== 16'd100) begin n_bad++; $display("FAIL sat_partial: got %0d exp 100", err_count_o); end
    repeat (65440) @(posedge clk);
    #1;
    valid_i = 1'b0; last_i = 1'b0;
    n_cmp++; if (err_count_o !== 16'hFFFF) begin n_bad++; $display("FAIL sat_cnt: got %h exp ffff", err_count_o); end
    step(); step();
    n_cmp++; if (err_o !== 1'b0 || err_count_o !== 16'hFFFF || valid_o !== 1'b0) begin
      n_bad++; $display("FAIL sat_hold: got e=%0b cnt=%h v=%0b exp 0 ffff 0", err_o, err_count_o, valid_o); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_early_last();
    test_missing_last();
    test_reset_mid();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
